// File: rtl/eq_cfg_loader_if.sv
// Byte-source and register-bank port bundle for the equalizer config loader.
// master = byte source / bank side, slave = loader.
interface eq_cfg_loader_if #(
    parameter int unsigned AW = 5
);
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data_out;
    logic          busy;
    logic          frame_ok;
    logic          frame_err;
    logic [1:0]    err_code;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, we, addr, data_out, busy, frame_ok, frame_err, err_code
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, we, addr, data_out, busy, frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/eq_cfg_loader.sv
// Framed byte-stream loader: stages a checksummed write frame, then commits it
// to the equalizer register bank as a burst of single-byte writes.
module eq_cfg_loader #(
    parameter int unsigned NUM_REGS    = 31,
    parameter int unsigned AW          = 5,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    eq_cfg_loader_if.slave     bus
);

    localparam int unsigned KW = $clog2(NUM_REGS);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GET_START,
        GET_LEN,
        GET_DATA,
        GET_CHK,
        COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    start_q, start_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [KW-1:0] k_q, k_d, k_nxt;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    logic          xfer;
    logic          timeout_hit;
    logic [8:0]    end_sum;
    logic [7:0]    stage_mem [NUM_REGS];

    assign xfer    = bus.rx_valid && ready_q;
    // START+LEN evaluated in 9 bits so a wrapping range is still rejected
    assign end_sum = 9'(start_q) + 9'(bus.rx_data);

    // Staging buffer: deliberately not reset, only indices < LEN are ever committed
    always_ff @(posedge clk) begin
        if (state_q == GET_DATA && xfer) begin
            stage_mem[k_q] <= bus.rx_data;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            start_q <= '0;
            len_q   <= '0;
            chk_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        len_d       = len_q;
        chk_d       = chk_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        ready_d     = 1'b1;
        busy_d      = 1'b0;
        k_nxt       = k_q + KW'(1);
        timeout_hit = 1'b0;

        // Inter-byte idle counter, active only while inside a frame
        if (state_q inside {GET_START, GET_LEN, GET_DATA, GET_CHK}) begin
            if (xfer) begin
                cnt_d = '0;
            end else begin
                cnt_d       = cnt_q + TW'(1);
                timeout_hit = (cnt_q == TW'(TIMEOUT_CYC - 1));
            end
        end

        case (state_q)
            IDLE: begin
                if (xfer && bus.rx_data == SYNC_BYTE) begin
                    state_d = GET_START;
                    code_d  = ERR_NONE;
                end
            end

            GET_START: begin
                if (xfer) begin
                    start_d = bus.rx_data;
                    chk_d   = bus.rx_data;
                    state_d = GET_LEN;
                end
            end

            GET_LEN: begin
                if (xfer) begin
                    if (bus.rx_data == 8'd0 || end_sum > 9'(NUM_REGS)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_RANGE;
                        state_d = IDLE;
                    end else begin
                        len_d   = bus.rx_data;
                        chk_d   = chk_q ^ bus.rx_data;
                        k_d     = '0;
                        state_d = GET_DATA;
                    end
                end
            end

            GET_DATA: begin
                if (xfer) begin
                    chk_d = chk_q ^ bus.rx_data;
                    k_d   = k_nxt;
                    if (8'(k_q) == len_q - 8'd1) begin
                        state_d = GET_CHK;
                    end
                end
            end

            GET_CHK: begin
                if (xfer) begin
                    if (bus.rx_data == chk_q) begin
                        // first write goes out in the cycle right after CHK
                        state_d = COMMIT;
                        k_d     = '0;
                        we_d    = 1'b1;
                        addr_d  = AW'(start_q);
                        data_d  = stage_mem[0];
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = IDLE;
                    end
                end
            end

            COMMIT: begin
                if (8'(k_q) == len_q - 8'd1) begin
                    state_d = IDLE;
                    ok_d    = 1'b1;
                    k_d     = '0;
                end else begin
                    k_d    = k_nxt;
                    we_d   = 1'b1;
                    addr_d = AW'(start_q + 8'(k_nxt));
                    data_d = stage_mem[k_nxt];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // timeout_hit implies no transfer this cycle, so it never races a byte
        if (timeout_hit) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = IDLE;
        end

        if (state_d == IDLE) begin
            cnt_d = '0;
        end

        ready_d = (state_d != COMMIT);
        busy_d  = (state_d != IDLE);
    end

    assign bus.rx_ready  = ready_q;
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.data_out  = data_q;
    assign bus.busy      = busy_q;
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_eq_cfg_loader.sv
// Directed testbench for eq_cfg_loader: frames, errors, timeout and mid-commit reset.
module tb_eq_cfg_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    eq_cfg_loader_if #(.AW(5)) bus ();

    eq_cfg_loader #(
        .NUM_REGS   (31),
        .AW         (5),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Bank model and write/pulse log, sampled mid-cycle
    logic [7:0] bank [0:31];
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int         wr_cyc [$];
    int         n_wr = 0, n_ok = 0, n_err = 0, n_rdy_wr = 0, cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.we) begin
                wr_addr.push_back(8'(bus.addr));
                wr_data.push_back(bus.data_out);
                wr_cyc.push_back(cyc);
                bank[bus.addr] = bus.data_out;
                n_wr++;
                if (bus.rx_ready) n_rdy_wr++;
            end
            if (bus.frame_ok)  n_ok++;
            if (bus.frame_err) n_err++;
        end
    end

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        n_wr = 0; n_ok = 0; n_err = 0; n_rdy_wr = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Present one byte and hold until the loader takes it
    task automatic send_byte(input logic [7:0] b);
        int w;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        w = 0;
        while (!bus.rx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            tests++; fails++;
            $display("FAIL send_byte: rx_ready got 0 want 1 for 50 cycles");
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        if (bus.rx_ready !== 1'b1) begin fails++; $display("FAIL rst_rx_ready: got %b want 1", bus.rx_ready); end
        tests++;
        if (bus.we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", bus.we); end
        tests++;
        if (bus.addr !== 5'd0 || bus.data_out !== 8'd0) begin fails++; $display("FAIL rst_addr_data: got %h/%h want 00/00", bus.addr, bus.data_out); end
        tests++;
        if (bus.busy !== 1'b0 || bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) begin
            fails++; $display("FAIL rst_flags: busy/ok/err got %b%b%b want 000", bus.busy, bus.frame_ok, bus.frame_err);
        end
        tests++;
        if (bus.err_code !== 2'b00) begin fails++; $display("FAIL rst_err_code: got %b want 00", bus.err_code); end
        tests++;
    endtask

    task automatic test_valid_frame();
        logic [7:0] f [7];
        f = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02};
        clear_logs();
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        @(negedge clk);
        if (bus.we !== 1'b1 || bus.addr !== 5'd1 || bus.data_out !== 8'h10 || bus.rx_ready !== 1'b0) begin
            fails++; $display("FAIL valid_first_we: we/addr/data/rdy got %b/%h/%h/%b want 1/01/10/0",
                              bus.we, bus.addr, bus.data_out, bus.rx_ready);
        end
        tests++;
        repeat (2) @(negedge clk);
        if (bus.we !== 1'b1 || bus.addr !== 5'd3 || bus.data_out !== 8'h30) begin
            fails++; $display("FAIL valid_third_we: we/addr/data got %b/%h/%h want 1/03/30", bus.we, bus.addr, bus.data_out);
        end
        tests++;
        @(negedge clk);
        if (bus.frame_ok !== 1'b1 || bus.we !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL valid_frame_ok: ok/we/busy got %b/%b/%b want 1/0/0", bus.frame_ok, bus.we, bus.busy);
        end
        tests++;
        wait_cycles(3);
        if (n_wr !== 3 || n_ok !== 1 || n_err !== 0) begin
            fails++; $display("FAIL valid_counts: wr/ok/err got %0d/%0d/%0d want 3/1/0", n_wr, n_ok, n_err);
        end
        tests++;
        if (bank[1] !== 8'h10 || bank[2] !== 8'h20 || bank[3] !== 8'h30) begin
            fails++; $display("FAIL valid_bank: got %h %h %h want 10 20 30", bank[1], bank[2], bank[3]);
        end
        tests++;
        if (bus.err_code !== 2'b00) begin fails++; $display("FAIL valid_err_code: got %b want 00", bus.err_code); end
        tests++;
    endtask

    task automatic test_full_bank();
        logic [7:0] d [31];
        logic [7:0] chk;
        int bad;
        clear_logs();
        chk = 8'h00 ^ 8'h1F;
        for (int i = 0; i < 31; i++) begin
            d[i] = 8'(i * 5 + 7);
            chk  = chk ^ d[i];
        end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h1F);
        for (int i = 0; i < 31; i++) send_byte(d[i]);
        send_byte(chk);
        wait_cycles(36);
        if (n_wr !== 31 || n_ok !== 1 || n_err !== 0) begin
            fails++; $display("FAIL full_counts: wr/ok/err got %0d/%0d/%0d want 31/1/0", n_wr, n_ok, n_err);
        end
        tests++;
        bad = 0;
        if (n_wr == 31) begin
            for (int i = 0; i < 31; i++) begin
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== d[i] || wr_cyc[i] !== wr_cyc[0] + i) bad++;
            end
        end
        if (bad !== 0) begin fails++; $display("FAIL full_burst: got %0d bad or non-consecutive writes want 0", bad); end
        tests++;
        if (n_rdy_wr !== 0) begin fails++; $display("FAIL full_rx_ready: got %0d write cycles with rx_ready=1 want 0", n_rdy_wr); end
        tests++;
    endtask

    task automatic test_range();
        clear_logs();
        send_byte(8'hA5); send_byte(8'h1E); send_byte(8'h02);
        @(negedge clk);
        if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b01 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL range_over: err/code/busy got %b/%b/%b want 1/01/0", bus.frame_err, bus.err_code, bus.busy);
        end
        tests++;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
        @(negedge clk);
        if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b01) begin
            fails++; $display("FAIL range_len0: err/code got %b/%b want 1/01", bus.frame_err, bus.err_code);
        end
        tests++;
        wait_cycles(2);
        if (n_wr !== 0 || n_err !== 2) begin
            fails++; $display("FAIL range_counts: wr/err got %0d/%0d want 0/2", n_wr, n_err);
        end
        tests++;
        // START+LEN == NUM_REGS exactly is still legal
        send_byte(8'hA5); send_byte(8'h1E); send_byte(8'h01); send_byte(8'h55); send_byte(8'h4A);
        wait_cycles(4);
        if (n_wr !== 1 || n_ok !== 1 || bank[30] !== 8'h55 || bus.err_code !== 2'b00) begin
            fails++; $display("FAIL range_edge: wr/ok/bank30/code got %0d/%0d/%h/%b want 1/1/55/00",
                              n_wr, n_ok, bank[30], bus.err_code);
        end
        tests++;
    endtask

    task automatic test_bad_chk();
        logic [7:0] f [7];
        f = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
        clear_logs();
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        @(negedge clk);
        if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b10) begin
            fails++; $display("FAIL chk_err: err/code got %b/%b want 1/10", bus.frame_err, bus.err_code);
        end
        tests++;
        wait_cycles(3);
        if (n_wr !== 0 || n_ok !== 0) begin fails++; $display("FAIL chk_no_write: wr/ok got %0d/%0d want 0/0", n_wr, n_ok); end
        tests++;
        send_byte(8'hA5);
        if (bus.err_code !== 2'b00 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL chk_sync_clear: code/busy got %b/%b want 00/1", bus.err_code, bus.busy);
        end
        tests++;
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h77); send_byte(8'h74);
        wait_cycles(4);
        if (n_wr !== 1 || n_ok !== 1 || bank[2] !== 8'h77) begin
            fails++; $display("FAIL chk_recover: wr/ok/bank2 got %0d/%0d/%h want 1/1/77", n_wr, n_ok, bank[2]);
        end
        tests++;
    endtask

    task automatic test_timeout();
        int n;
        clear_logs();
        send_byte(8'hA5); send_byte(8'h01);
        n = 0;
        while (!bus.frame_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        // 16 idle edges after START, pulse sampled on the following negedge
        if (n !== 17) begin fails++; $display("FAIL timeout_cycles: got %0d want 17", n); end
        tests++;
        if (bus.err_code !== 2'b11 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL timeout_code: code/busy got %b/%b want 11/0", bus.err_code, bus.busy);
        end
        tests++;
        @(negedge clk);
        if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL timeout_pulse: got %b want 0", bus.frame_err); end
        tests++;
        clear_logs();
        send_byte(8'h00); send_byte(8'hFF);
        wait_cycles(3);
        if (n_ok !== 0 || n_err !== 0 || bus.busy !== 1'b0 || bus.err_code !== 2'b11) begin
            fails++; $display("FAIL garbage_idle: ok/err/busy/code got %0d/%0d/%b/%b want 0/0/0/11",
                              n_ok, n_err, bus.busy, bus.err_code);
        end
        tests++;
    endtask

    task automatic test_reset_mid_commit();
        logic [7:0] f [7];
        f = '{8'hA5, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDF};
        clear_logs();
        for (int i = 0; i < 32; i++) bank[i] = 8'h00;
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        if (bus.we !== 1'b0 || bus.addr !== 5'd0 || bus.data_out !== 8'd0) begin
            fails++; $display("FAIL rstc_we: we/addr/data got %b/%h/%h want 0/00/00", bus.we, bus.addr, bus.data_out);
        end
        tests++;
        if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0 || bus.frame_ok !== 1'b0 || bus.err_code !== 2'b00) begin
            fails++; $display("FAIL rstc_flags: rdy/busy/ok/code got %b/%b/%b/%b want 1/0/0/00",
                              bus.rx_ready, bus.busy, bus.frame_ok, bus.err_code);
        end
        tests++;
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(4);
        if (n_wr !== 2 || n_ok !== 0) begin fails++; $display("FAIL rstc_counts: wr/ok got %0d/%0d want 2/0", n_wr, n_ok); end
        tests++;
        if (bank[1] !== 8'hAA || bank[2] !== 8'hBB || bank[3] !== 8'h00) begin
            fails++; $display("FAIL rstc_bank: got %h %h %h want AA BB 00", bank[1], bank[2], bank[3]);
        end
        tests++;
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < 32; i++) bank[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_cycles(2);
        test_reset();
        test_valid_frame();
        test_full_bank();
        test_range();
        test_bad_chk();
        test_timeout();
        test_reset_mid_commit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time got 100000 want less");
        $fatal(1, "watchdog expired");
    end

endmodule
